// File: rtl/seq_mul16_addctl_if.sv
// Bundles the multiplier request/result signals with the external 16-bit adder
// port (A, B, cin out; R back combinationally). slave = multiplier, master = environment.
interface seq_mul16_addctl_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH-1:0]   add_r;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, op_a, op_b, add_r,
    input  add_a, add_b, add_cin, busy, done, product
  );

  modport slave (
    input  start, op_a, op_b, add_r,
    output add_a, add_b, add_cin, busy, done, product
  );
endinterface

// File: rtl/seq_mul16_addctl.sv
// 16x16 shift-and-add multiplier on an external 16-bit adder; done 17 cycles after accept, start ignored while busy.
// MUL_ZERO_BYPASS_EN: a zero operand skips RUN and completes in 2 cycles.
module seq_mul16_addctl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic             clk,
  input logic             reset,
  seq_mul16_addctl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   add_a_w, add_b_w;
  logic               add_cin_w;
  logic               cout;
  logic               zero_op;

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (bus.op_a == '0) || (bus.op_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_comb begin
    add_a_w   = '0;
    add_b_w   = '0;
    add_cin_w = 1'b0;
    if (state_q == RUN) begin
      add_a_w = acc_q;
      add_b_w = mq_q[0] ? mcand_q : '0;
    end
  end

  // The adder drops its carry; recover it from the operand MSBs and the sum MSB.
  assign cout = (add_a_w[WIDTH-1] & add_b_w[WIDTH-1]) |
                ((add_a_w[WIDTH-1] ^ add_b_w[WIDTH-1]) & ~bus.add_r[WIDTH-1]);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = bus.op_a;
          // Zeroing mq on bypass makes the DONE capture {acc,mq} yield 0.
          mq_d    = zero_op ? '0 : bus.op_b;
          acc_d   = '0;
          count_d = '0;
          state_d = zero_op ? DONE : RUN;
        end
      end
      RUN: begin
        acc_d   = {cout, bus.add_r[WIDTH-1:1]};
        mq_d    = {bus.add_r[0], mq_q[WIDTH-1:1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH-1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        product_d = {acc_q, mq_q};
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mq_q      <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign bus.add_a   = add_a_w;
  assign bus.add_b   = add_b_w;
  assign bus.add_cin = add_cin_w;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mul16_addctl.sv
// Scoreboard bench for seq_mul16_addctl: driver queues expected products and done cycles, monitor checks on done.
module tb_seq_mul16_addctl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_mul16_addctl_if #(.WIDTH(16)) bus ();

  // Behavioural model of the downstream 16-bit CLA adder (no carry-out).
  assign bus.add_r = bus.add_a + bus.add_b + {15'd0, bus.add_cin};

  seq_mul16_addctl #(.WIDTH(16), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] prod;
    int          done_cyc;
    int          busy_exp;
    logic [15:0] mcand;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  int          ndone = 0;
  logic [31:0] hold_exp = 32'd0;
  bit          idle_or_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: adder drive per state, product hold, and scoreboard pop on done.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.busy) busy_cnt++;
      idle_or_done = !bus.busy || (sb.size() > 0 && cyc == sb[0].done_cyc - 1);
      if (idle_or_done)
        chk(bus.add_a == 16'd0 && bus.add_b == 16'd0 && !bus.add_cin, "adder_idle",
            {bus.add_a, bus.add_b}, 32'd0);
      else if (sb.size() > 0)
        chk(!bus.add_cin && (bus.add_b == 16'd0 || bus.add_b == sb[0].mcand), "adder_run",
            {15'd0, bus.add_cin, bus.add_b}, {16'd0, sb[0].mcand});
      if (bus.done) begin
        ndone++;
        chk(sb.size() > 0, "done_expected", bus.product, 32'd0);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk(bus.product == e.prod, "product", bus.product, e.prod);
          chk(cyc == e.done_cyc, "done_latency", cyc, e.done_cyc);
          chk(busy_cnt == e.busy_exp, "busy_cycles", busy_cnt, e.busy_exp);
          hold_exp = e.prod;
        end
        busy_cnt = 0;
      end else begin
        chk(bus.product == hold_exp, "product_hold", bus.product, hold_exp);
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [31:0] prod);
    exp_t e;
    int   lat;
    lat = 18;
`ifdef MUL_ZERO_BYPASS_EN
    if (a == 16'd0 || b == 16'd0) lat = 2;
`endif
    @(negedge clk);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    e.prod     = prod;
    e.done_cyc = cyc + lat;
    e.busy_exp = lat - 1;
    e.mcand    = a;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    for (int i = 0; i < 40 && ndone == n0; i++) begin
      @(negedge clk);
      #1;
    end
    chk(ndone > n0, "done_timeout", ndone, n0 + 1);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [31:0] prod);
    int n0;
    n0 = ndone;
    issue(a, b, prod);
    wait_done(n0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [15:0] ra, rb;
    bus.start = 1'b0;
    bus.op_a  = 16'd0;
    bus.op_b  = 16'd0;
    #1;
    chk(bus.done == 1'b0, "rst_done", {31'd0, bus.done}, 32'd0);
    chk(bus.busy == 1'b0, "rst_busy", {31'd0, bus.busy}, 32'd0);
    chk(bus.product == 32'd0, "rst_product", bus.product, 32'd0);
    chk(bus.add_a == 16'd0 && bus.add_b == 16'd0 && !bus.add_cin, "rst_adder",
        {bus.add_a, bus.add_b}, 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;

    run(16'd3, 16'd5, 32'h0000_000F);
    run(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);

    // Second start mid-RUN must be ignored.
    n0 = ndone;
    issue(16'h1234, 16'h00FF, 32'h0012_21CC);
    repeat (4) @(negedge clk);
    bus.op_a  = 16'd7;
    bus.op_b  = 16'd7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n0);
    repeat (20) @(negedge clk);
    chk(ndone == n0 + 1, "single_done", ndone, n0 + 1);

    // Reset in the middle of a RUN.
    issue(16'd100, 16'd200, 32'h0000_4E20);
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk(bus.done == 1'b0, "midrst_done", {31'd0, bus.done}, 32'd0);
    chk(bus.busy == 1'b0, "midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk(bus.product == 32'd0, "midrst_product", bus.product, 32'd0);
    sb.delete();
    hold_exp = 32'd0;
    busy_cnt = 0;
    @(negedge clk);
    #2 reset = 1'b0;
    run(16'd100, 16'd200, 32'h0000_4E20);

    run(16'h0000, 16'hABCD, 32'h0000_0000);
    run(16'hABCD, 16'h0000, 32'h0000_0000);
    run(16'h8000, 16'h8000, 32'h4000_0000);
    run(16'hFFFF, 16'h0001, 32'h0000_FFFF);

    for (int k = 0; k < 300; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run(ra, rb, {16'd0, ra} * {16'd0, rb});
    end

    repeat (5) @(negedge clk);
    chk(sb.size() == 0, "sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
